// File: rtl/seg_display_mux_pkg.sv
// ---------------------------------------------------------------------------
// seg_display_pkg
//   Shared constants for the multiplexed seven-segment display driver.
//   Segment vectors are ordered {a,b,c,d,e,f,g,dp}, active high, so bit 7 is
//   segment a and bit 0 is the decimal point.
//   Contents:
//     SEG_W          width of a segment vector
//     SEG_A..SEG_DP  bit positions of each segment inside a segment vector
//     HEX_SEG        16-entry hex glyph table (dp bit always 0)
//     hex_to_seg()   table lookup helper
// ---------------------------------------------------------------------------
package seg_display_pkg;

    localparam int SEG_W  = 8;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Glyphs 0-9, A, b, C, d, E, F
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2,
        8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E,
        8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg_display_mux_decode.sv
// ---------------------------------------------------------------------------
// hex7seg_decode
//   Combinational glyph decoder: one hex nibble plus decimal point plus blank
//   request in, one active-high segment vector {a..g,dp} out.
//   A blanked digit drops segments a..g but keeps its decimal point.
//   Ports:
//     nibble  in   4      hex value to display
//     dp      in   1      decimal point request
//     blank   in   1      suppress segments a..g
//     seg     out  SEG_W  segment pattern
// ---------------------------------------------------------------------------
module hex7seg_decode
    import seg_display_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             dp,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg         = blank ? '0 : hex_to_seg(nibble);
        seg[SEG_DP] = dp;
    end

endmodule

// File: rtl/seg_display_mux.sv
// ---------------------------------------------------------------------------
// seg_display_mux
//   Multiplexed NUM_DIGITS-digit seven-segment driver with refresh prescaler,
//   PWM brightness, leading-zero blanking, per-digit decimal points and
//   frame-synchronous (tear-free) data update.
//   Optional build macro: SEG_ACTIVE_LOW_EN -- when defined, anodes and seg
//   are inverted at the output registers (reset/dark/blanked drive all-ones).
//   Ports:
//     clk         in   1               system clock
//     rst         in   1               synchronous active-high reset
//     data        in   4*NUM_DIGITS    hex nibbles, nibble 0 = rightmost
//     dp_mask     in   NUM_DIGITS      decimal point enable per digit
//     load        in   1               capture data/dp_mask into pending
//     blank_lz    in   1               leading-zero blanking enable
//     brightness  in   BRIGHT_WIDTH    0 = dark, all-ones = full on
//     anodes      out  NUM_DIGITS      one-hot digit enable
//     seg         out  8               {a,b,c,d,e,f,g,dp}
//     frame_tick  out  1               pulse in the cycle after index wraps
// ---------------------------------------------------------------------------
module seg_display_mux
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_WIDTH    = 16,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [BRIGHT_WIDTH-1:0]   brightness,
    output logic [NUM_DIGITS-1:0]     anodes,
    output logic [SEG_W-1:0]          seg,
    output logic                      frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    // Idle (dark) output levels; also used as the inversion mask.
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{OUT_INV}};
    localparam logic [SEG_W-1:0]      SEG_IDLE = {SEG_W{OUT_INV}};

    logic [DIV_WIDTH-1:0]    prescaler_reg;
    logic [IDX_W-1:0]        index_reg;
    logic [4*NUM_DIGITS-1:0] pending_reg;
    logic [NUM_DIGITS-1:0]   pend_dp_reg;
    logic                    pend_valid_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic [NUM_DIGITS-1:0]   anodes_reg;
    logic [SEG_W-1:0]        seg_reg;
    logic                    frame_tick_reg;

    logic [NUM_DIGITS-1:0]   anodes_next;
    logic [SEG_W-1:0]        seg_next;

    logic                    presc_wrap;
    logic                    frame_wrap;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   nib_zero;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [BRIGHT_WIDTH-1:0] pwm_level;
    logic                    pwm_on;
    logic [SEG_W-1:0]        dec_seg;

    assign presc_wrap = (prescaler_reg == '1);
    assign frame_wrap = presc_wrap && (index_reg == LAST_IDX);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi]      = shadow_reg[4*gi +: 4];
            assign nib_zero[gi] = (shadow_reg[4*gi +: 4] == 4'd0);
        end
    endgenerate

    // Digit i is a leading zero when it and every digit to its left are zero.
    // Scanned from the leftmost digit down; digit 0 always stays visible.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && nib_zero[i];
            lz_blank[i] = blank_lz && (i != 0) && zero_run;
        end
    end

    assign cur_nib   = nib[index_reg];
    assign cur_dp    = shadow_dp_reg[index_reg];
    assign cur_blank = lz_blank[index_reg];

    // Top prescaler bits act as a sawtooth; full scale bypasses the compare
    // so all-ones brightness really is 100% duty.
    assign pwm_level = prescaler_reg[DIV_WIDTH-1 -: BRIGHT_WIDTH];
    assign pwm_on    = (brightness == '1) || (pwm_level < brightness);

    hex7seg_decode u_decode (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    // A blanked digit without a decimal point is fully dark, anode included.
    always_comb begin
        anodes_next = '0;
        seg_next    = '0;
        if (pwm_on && !(cur_blank && !cur_dp)) begin
            anodes_next = NUM_DIGITS'(1) << index_reg;
            seg_next    = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_reg  <= '0;
            index_reg      <= '0;
            pending_reg    <= '0;
            pend_dp_reg    <= '0;
            pend_valid_reg <= 1'b0;
            shadow_reg     <= '0;
            shadow_dp_reg  <= '0;
            anodes_reg     <= AN_IDLE;
            seg_reg        <= SEG_IDLE;
            frame_tick_reg <= 1'b0;
        end else begin
            prescaler_reg <= prescaler_reg + DIV_WIDTH'(1);
            if (presc_wrap) begin
                index_reg <= frame_wrap ? '0 : index_reg + IDX_W'(1);
            end

            // Shadow only changes between frames so a frame never mixes
            // old and new digits.
            if (frame_wrap) begin
                if (pend_valid_reg) begin
                    shadow_reg    <= pending_reg;
                    shadow_dp_reg <= pend_dp_reg;
                end
                pend_valid_reg <= 1'b0;
            end

            // Placed after the frame update so a load coinciding with the
            // wrap stays pending for the following frame.
            if (load) begin
                pending_reg    <= data;
                pend_dp_reg    <= dp_mask;
                pend_valid_reg <= 1'b1;
            end

            frame_tick_reg <= frame_wrap;
            anodes_reg     <= anodes_next ^ AN_IDLE;
            seg_reg        <= seg_next ^ SEG_IDLE;
        end
    end

    assign anodes     = anodes_reg;
    assign seg        = seg_reg;
    assign frame_tick = frame_tick_reg;

endmodule
